// File: rtl/cam_capture_320.sv
// Camera RGB565 byte-stream to 320x240 frame-buffer write port, PCLK domain.
// Define CAPTURE_DOWNSCALE_EN for a 640x480 source decimated 2:1 in x and y.
module cam_capture_320 #(
  parameter int H_PIX   = 320,
  parameter int V_LINES = 240,
  parameter int ADDR_W  = 17
) (
  input  logic              PCLK,
  input  logic              RST,
  input  logic              VSYNC,
  input  logic              HREF,
  input  logic [7:0]        D,
  input  logic              capture_en,
  output logic              we,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [15:0]       wr_data,
  output logic              frame_done,
  output logic              line_err,
  output logic [8:0]        line_count
);

`ifdef CAPTURE_DOWNSCALE_EN
  localparam int SHIFT = 1;
`else
  localparam int SHIFT = 0;
`endif
  localparam logic [9:0] H_LIM = 10'(H_PIX);
  localparam logic [9:0] V_LIM = 10'(V_LINES);
  localparam logic [9:0] SRC_W = 10'(H_PIX << SHIFT);

  typedef enum logic [1:0] {S_SYNC, S_FRAME, S_LINE} state_t;
  state_t state, state_nxt;

  logic              vs_q, href_q;
  logic              vs_fall, vs_rise, href_fall;
  logic [9:0]        src_x, src_y, dst_x, dst_y;
  logic              phase;
  logic [7:0]        byte0;
  logic              take_b0, take_pix, line_end, line_abort, frame_end;
  logic              keep, in_range;
  logic [ADDR_W-1:0] y_ext, addr;

  assign vs_fall   = vs_q & ~VSYNC;
  assign vs_rise   = ~vs_q & VSYNC;
  assign href_fall = href_q & ~HREF;

  assign dst_x = src_x >> SHIFT;
  assign dst_y = src_y >> SHIFT;
`ifdef CAPTURE_DOWNSCALE_EN
  assign keep = ~src_x[0] & ~src_y[0];
`else
  assign keep = 1'b1;
`endif
  assign in_range = keep && (dst_x < H_LIM) && (dst_y < V_LIM);

  // y*320 as (y<<8)+(y<<6); tops out at 76799 so never wraps ADDR_W bits
  assign y_ext = ADDR_W'(dst_y);
  assign addr  = (y_ext << 8) + (y_ext << 6) + ADDR_W'(dst_x);

  always_ff @(posedge PCLK or posedge RST) begin
    if (RST) state <= S_SYNC;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    take_b0    = 1'b0;
    take_pix   = 1'b0;
    line_end   = 1'b0;
    line_abort = 1'b0;
    frame_end  = 1'b0;
    case (state)
      S_SYNC: begin
        if (vs_fall && capture_en) state_nxt = S_FRAME;
      end
      S_FRAME: begin
        if (vs_rise) begin
          frame_end = 1'b1;
          state_nxt = S_SYNC;
        end else if (HREF) begin
          take_b0   = 1'b1;
          state_nxt = S_LINE;
        end
      end
      S_LINE: begin
        // vs_rise takes priority but still closes a line ending on the same edge
        if (vs_rise) begin
          frame_end  = 1'b1;
          line_end   = href_fall;
          line_abort = ~href_fall;
          state_nxt  = S_SYNC;
        end else if (href_fall) begin
          line_end  = 1'b1;
          state_nxt = S_FRAME;
        end else if (HREF) begin
          take_pix = phase;
          take_b0  = ~phase;
        end
      end
      default: state_nxt = S_SYNC;
    endcase
  end

  always_ff @(posedge PCLK or posedge RST) begin
    if (RST) begin
      vs_q       <= 1'b0;
      href_q     <= 1'b0;
      src_x      <= '0;
      src_y      <= '0;
      phase      <= 1'b0;
      byte0      <= '0;
      we         <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      frame_done <= 1'b0;
      line_err   <= 1'b0;
      line_count <= '0;
    end else begin
      vs_q       <= VSYNC;
      href_q     <= HREF;
      we         <= 1'b0;
      frame_done <= 1'b0;
      if (vs_fall) begin
        src_x    <= '0;
        src_y    <= '0;
        phase    <= 1'b0;
        line_err <= 1'b0;
      end
      if (take_b0) begin
        byte0 <= D;
        phase <= 1'b1;
      end
      if (take_pix) begin
        phase <= 1'b0;
        src_x <= (src_x == '1) ? src_x : src_x + 10'd1;
        if (in_range) begin
          we      <= 1'b1;
          wr_data <= {byte0, D};
          wr_addr <= addr;
        end
      end
      if (line_end) begin
        src_x <= '0;
        phase <= 1'b0;
        src_y <= (src_y == '1) ? src_y : src_y + 10'd1;
        if (phase || src_x != SRC_W) line_err <= 1'b1;
      end
      if (line_abort) begin
        phase    <= 1'b0;
        line_err <= 1'b1;
      end
      if (frame_end) begin
        frame_done <= 1'b1;
        line_count <= line_end ? 9'(src_y + 10'd1) : 9'(src_y);
      end
    end
  end

endmodule

// File: tb/tb_cam_capture_320.sv
// Directed frame sequence with random pixel data, checked against a line/pixel level model.
module tb_cam_capture_320;
`ifdef CAPTURE_DOWNSCALE_EN
  localparam int SC = 2;
`else
  localparam int SC = 1;
`endif
  localparam int W = 320 * SC;

  logic        PCLK = 1'b0;
  logic        RST, VSYNC, HREF, capture_en;
  logic [7:0]  D;
  logic        we, frame_done, line_err;
  logic [16:0] wr_addr;
  logic [15:0] wr_data;
  logic [8:0]  line_count;

  int checks = 0, errors = 0, fd_cnt = 0;
  bit cap = 0, ferr = 0;
  logic we_prev = 1'b0;
  int exp_addr[$];
  logic [15:0] exp_data[$];

  cam_capture_320 dut (
    .PCLK(PCLK), .RST(RST), .VSYNC(VSYNC), .HREF(HREF), .D(D),
    .capture_en(capture_en), .we(we), .wr_addr(wr_addr), .wr_data(wr_data),
    .frame_done(frame_done), .line_err(line_err), .line_count(line_count)
  );

  always #5 PCLK = ~PCLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic tick(input logic vs, input logic hr, input logic [7:0] d);
    VSYNC = vs; HREF = hr; D = d;
    @(posedge PCLK); #1;
    if (frame_done) fd_cnt++;
    if (we) begin
      chk("we_back2back", we_prev, 0);
      if (exp_addr.size() == 0) chk("unexpected_we", we, 0);
      else begin
        chk("wr_addr", wr_addr, exp_addr.pop_front());
        chk("wr_data", wr_data, exp_data.pop_front());
      end
    end
    we_prev = we;
  endtask

  task automatic do_reset();
    #2 RST = 1'b1;
    #1;
    chk("rst_we", we, 0);
    chk("rst_wr_addr", wr_addr, 0);
    chk("rst_wr_data", wr_data, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_line_err", line_err, 0);
    chk("rst_line_count", line_count, 0);
    tick(VSYNC, HREF, D);
    RST = 1'b0;
    cap = 0;
  endtask

  task automatic start_frame();
    repeat (2) tick(1, 0, 0);
    tick(0, 0, 0);
    cap = capture_en;
    ferr = 0;
    chk("line_err_clear", line_err, 0);
    repeat (2) tick(0, 0, 0);
  endtask

  task automatic send_line(input int ly, input int nbytes, input int gap, input int rst_at);
    logic [7:0] d, b0;
    bit want;
    b0 = 8'h00;
    for (int b = 0; b < nbytes; b++) begin
      if (b == rst_at) do_reset();
      d = 8'($urandom);
      want = 0;
      if (b % 2 == 0) b0 = d;
      else begin
        int px = b / 2;
        if (cap && px % SC == 0 && ly % SC == 0 && px / SC < 320 && ly / SC < 240) begin
          want = 1;
          exp_addr.push_back((ly / SC) * 320 + px / SC);
          exp_data.push_back({b0, d});
        end
      end
      tick(0, 1, d);
      chk("we_pixel", we, want);
    end
    if (cap && (nbytes % 2 != 0 || nbytes != 2 * W)) ferr = 1;
    for (int g = 0; g < gap; g++) begin
      tick(0, 0, 0);
      if (g == 0) chk("we_line_end", we, 0);
    end
  endtask

  task automatic end_frame(input logic hr_first, input int lines);
    int fd0 = fd_cnt;
    if (hr_first && cap) ferr = 1;
    tick(1, hr_first, 8'h5a);
    if (hr_first) chk("we_abort", we, 0);
    repeat (3) tick(1, 0, 0);
    chk("frame_done_cnt", fd_cnt - fd0, cap ? 1 : 0);
    chk("line_err", line_err, cap ? ferr : 0);
    if (cap && lines >= 0) chk("line_count", line_count, lines);
    chk("writes_pending", exp_addr.size(), 0);
    cap = 0;
  endtask

  initial begin
    RST = 1'b1; VSYNC = 1'b1; HREF = 1'b0; D = 8'h00; capture_en = 1'b1;
    repeat (3) @(posedge PCLK);
    #1;
    chk("init_we", we, 0);
    chk("init_wr_addr", wr_addr, 0);
    chk("init_wr_data", wr_data, 0);
    chk("init_frame_done", frame_done, 0);
    chk("init_line_err", line_err, 0);
    chk("init_line_count", line_count, 0);
    RST = 1'b0;
    repeat (2) tick(1, 0, 0);

    // clean frame; capture_en dropped mid-frame; last line ends with vs_rise
    start_frame();
    capture_en = 1'b0;
    for (int ly = 0; ly < 4 * SC; ly++)
      send_line(ly, 2 * W, (ly == 4 * SC - 1) ? 0 : $urandom_range(1, 4), -1);
    end_frame(1'b0, 4 * SC);

    // capture_en low at frame start: frame ignored even if re-enabled mid-frame
    start_frame();
    capture_en = 1'b1;
    for (int ly = 0; ly < 2; ly++) send_line(ly, 2 * W, 3, -1);
    end_frame(1'b0, 2);

    // odd byte count on one line
    start_frame();
    for (int ly = 0; ly < 3 * SC; ly++)
      send_line(ly, (ly == SC) ? 2 * W + 1 : 2 * W, 2, -1);
    end_frame(1'b0, 3 * SC);

    // oversize frame: 250 lines, one long line at the last stored row
    start_frame();
    for (int ly = 0; ly < 250 * SC; ly++)
      send_line(ly, (ly == 239 * SC) ? 2 * 330 * SC : 2 * $urandom_range(1, 3),
                $urandom_range(1, 2), -1);
    end_frame(1'b0, 250 * SC);

    // line aborted by vs_rise while HREF high
    start_frame();
    send_line(0, 2 * W, 2, -1);
    send_line(1, 101, 0, -1);
    end_frame(1'b1, -1);

    // reset mid-line, frame continues uncaptured
    start_frame();
    send_line(0, 2 * W, 2, -1);
    send_line(1, 2 * W, 2, -1);
    send_line(2, 2 * W, 2, 100);
    send_line(3, 2 * W, 2, -1);
    end_frame(1'b0, -1);
    chk("line_count_after_rst", line_count, 0);

    // recovered capture
    start_frame();
    for (int ly = 0; ly < 2 * SC; ly++) send_line(ly, 2 * W, 2, -1);
    end_frame(1'b0, 2 * SC);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/cam_capture_320.md
Name: cam_capture_320

Overview:
- Frame-buffer writer that pairs with the 640x480 VGA scan-out, which reads a 320x240 buffer at address y*320+x.
- Deserialises the camera's 8-bit parallel RGB565 stream (VSYNC/HREF/byte clock) into 16-bit pixels.
- Generates the matching frame-buffer write address and write enable, plus frame/line status.
- Sits between the camera pins and the dual-port frame buffer write port, in the camera pixel-clock domain.

Parameters:
- H_PIX, 320, stored pixels per line; pixels with x >= H_PIX are discarded.
- V_LINES, 240, stored lines per frame; lines with y >= V_LINES are discarded.
- ADDR_W, 17, frame-buffer address width; must satisfy 2^ADDR_W >= H_PIX*V_LINES.

Ports:
- PCLK  in  1  camera pixel (byte) clock; all logic on rising edge.
- RST  in  1  asynchronous, active-high reset.
- VSYNC  in  1  camera vertical sync; high = inter-frame gap.
- HREF  in  1  camera line valid; high = bytes on D are valid.
- D  in  8  camera data byte.
- capture_en  in  1  level; sampled only at frame start.
- we  out  1  frame-buffer write strobe, one PCLK per pixel.
- wr_addr  out  ADDR_W  write address = y*H_PIX + x.
- wr_data  out  16  RGB565 pixel {byte0, byte1}.
- frame_done  out  1  one-cycle pulse at the end of a captured frame.
- line_err  out  1  sticky per frame; set on a malformed line.
- line_count  out  9  number of lines seen in the last completed frame.

Behaviour:
- Reset (async): we=0, wr_addr=0, wr_data=0, frame_done=0, line_err=0, line_count=0, x=y=0, byte phase=0, state=S_SYNC.
- Edge detection uses registered copies of VSYNC and HREF. vs_fall = frame start. vs_rise = frame end. href_fall = line end.
- States:
  - S_SYNC: ignore all data. On vs_fall -> S_FRAME if capture_en=1, else stay in S_SYNC. This discards any partial frame after reset.
  - S_FRAME (between lines): on HREF=1 -> S_LINE, sampling the byte as byte0 in that same cycle. On vs_rise -> S_SYNC, pulse frame_done, latch line_count=y.
  - S_LINE: the byte phase toggles each cycle HREF=1.
    - Phase 0: store byte0.
    - Phase 1: form the pixel. If x < H_PIX and y < V_LINES, then on the next edge we=1, wr_data={byte0,D}, wr_addr=y*H_PIX+x. x increments regardless.
    - On href_fall: y+1, x=0, phase=0, -> S_FRAME.
- Latency: we is asserted on the edge after byte1 is sampled (1 PCLK). we is never high in two consecutive cycles.
- Address arithmetic: y*320 is computed as (y<<8)+(y<<6) at ADDR_W bits, plus zero-extended x. Maximum value 76799; no wrap.
- Odd byte count at href_fall: drop the partial pixel, no write, set line_err.
- Line length != 2*H_PIX bytes: set line_err. Writes for x < H_PIX still occur.
- vs_rise while HREF=1 (line aborted): finish as a vs_rise; drop any partial pixel; set line_err.
- line_err and the x/y counters clear on vs_fall. line_count and frame_done are untouched by vs_fall.
- capture_en deasserted mid-frame: the current frame completes. The next vs_fall stays in S_SYNC.
- Simultaneous vs_rise and href_fall: vs_rise wins. y increments once before line_count is latched.
- RST asserted mid-line: immediate return to reset values. No write is issued for the in-flight pixel.

Optional Feature:
- CAPTURE_DOWNSCALE_EN defined: the source is 640x480. Only pixels with even source x and lines with even source y are written; stored x = src_x>>1 and y = src_y>>1.
- The source counters in this mode are 10 bits wide. line_count reports source lines.
- CAPTURE_DOWNSCALE_EN not defined: the source is 320x240 (QVGA) and is stored 1:1.

Test Plan:
- Reset, then one clean 320x240 frame with byte pair (0xA5,0x3C) at every pixel -> 76800 writes, first wr_addr=0, last 76799, wr_data=0xA53C, one frame_done, line_count=240, line_err=0.
- Assert RST at line 10, pixel 50; release, then send 2 frames -> no writes until the first vs_fall after release; the next full frame writes 76800.
- Line 5 has 641 bytes (odd) -> 320 writes on that line, no 321st write, line_err=1; line_err clears at the next vs_fall.
- capture_en=0 at a vs_fall -> zero writes for that frame and no frame_done; re-enable -> the following frame is captured.
- Frame with 250 lines of 330 pixels -> writes only for x<320 and y<240 (76800 total), line_count=250, line_err=1.
- CAPTURE_DOWNSCALE_EN defined, 640x480 frame where each pixel's value is src_x + src_y*640 -> 76800 writes; the pixel at wr_addr=321 equals the source pixel at src (2,2).
